// File: rtl/tf_gen_param.sv
// tf_gen_param: LANES-wide twiddle-factor generator.
// Each lane follows tf[k+1] = tf[k] * c mod q, starting from a loaded base.
// The forward or inverse constant set is chosen when the run starts.
//
// Handshake: a vector transfers in any cycle where out_valid && out_ready.
// out_valid is never withdrawn without a transfer, except by abort or reset.
// While out_valid is high and out_ready is low, tf_out and step_idx are held stable.
module tf_gen_param #(
  parameter int DW      = 32,
  parameter int LANES   = 15,
  parameter int STEPS_W = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [STEPS_W-1:0]    num_steps,
  input  logic [LANES*DW-1:0]   base_in,
  input  logic [LANES*DW-1:0]   const_fwd_in,
  input  logic [LANES*DW-1:0]   const_inv_in,
  input  logic [DW-1:0]         modulus,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   tf_out,
  output logic [STEPS_W-1:0]    step_idx,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int PW    = 2 * DW;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      lane_q [LANES];
  logic [DW-1:0]      cst_q  [LANES];
  logic [DW-1:0]      mod_q;
  logic [STEPS_W-1:0] num_q;
  logic [STEPS_W-1:0] k_q;
  logic [PW-1:0]      prod_q [MUL_LAT][LANES];
  logic [DW-1:0]      red    [LANES];

  logic load_run;
  logic issue;
  logic commit;
  logic pipe_en;
  logic last_step;

  assign last_step = (k_q == num_q - STEPS_W'(1));
  // The product pipeline only moves while a multiply is in flight.
  assign pipe_en   = issue || (state_q == S_WAIT);

  // State register and countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort wins over any handshake in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_run = 1'b0;
    issue    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_steps != '0) begin
            load_run = 1'b1;
            state_d  = S_EMIT;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_EMIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Run context: captured at start, lanes advanced when a multiply result lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
        cst_q[i]  <= '0;
      end
      mod_q <= '0;
      num_q <= '0;
      k_q   <= '0;
    end else if (load_run) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= base_in[i*DW +: DW];
        cst_q[i]  <= mode ? const_inv_in[i*DW +: DW] : const_fwd_in[i*DW +: DW];
      end
      mod_q <= modulus;
      num_q <= num_steps;
      k_q   <= '0;
    end else if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= red[i];
      end
      k_q <= k_q + STEPS_W'(1);
    end
  end

  // Multiplier pipeline: full 2*DW products, delayed to MUL_LAT cycles total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < MUL_LAT; j++) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[j][i] <= '0;
        end
      end
    end else if (pipe_en) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[0][i] <= PW'(lane_q[i]) * PW'(cst_q[i]);
      end
      for (int j = 1; j < MUL_LAT; j++) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[j][i] <= prod_q[j-1][i];
        end
      end
    end
  end

  // Exact reduction of the last pipeline stage by the captured modulus.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      red[i] = DW'(prod_q[MUL_LAT-1][i] % PW'(mod_q));
    end
  end

  // Output packing; tf_out always mirrors the lane registers.
  always_comb begin
    tf_out = '0;
    for (int i = 0; i < LANES; i++) begin
      tf_out[i*DW +: DW] = lane_q[i];
    end
  end

  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign step_idx  = k_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tf_gen_param.sv
// Directed bench for tf_gen_param: runs the forward, inverse, back-pressure,
// zero-length, busy-start, abort and mid-run reset scenarios against
// hand values and a (a*b) mod q lane model.
module tb_tf_gen_param;

  localparam int DW      = 32;
  localparam int LANES   = 15;
  localparam int STEPS_W = 4;
  localparam int MUL_LAT = 3;
  localparam int VW      = LANES * DW;

  logic               clk;
  logic               rst;
  logic               start;
  logic               mode;
  logic [STEPS_W-1:0] num_steps;
  logic [VW-1:0]      base_in;
  logic [VW-1:0]      const_fwd_in;
  logic [VW-1:0]      const_inv_in;
  logic [DW-1:0]      modulus;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [VW-1:0]      tf_out;
  logic [STEPS_W-1:0] step_idx;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  tf_gen_param #(
    .DW(DW), .LANES(LANES), .STEPS_W(STEPS_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_steps(num_steps),
    .base_in(base_in), .const_fwd_in(const_fwd_in), .const_inv_in(const_inv_in),
    .modulus(modulus), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .tf_out(tf_out), .step_idx(step_idx), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [DW-1:0] lane0_q[$];

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mulvec(input logic [VW-1:0] a, input logic [VW-1:0] c,
                                          input logic [DW-1:0] q);
    logic [VW-1:0]   r;
    logic [2*DW-1:0] p;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      p = {{DW{1'b0}}, a[i*DW +: DW]} * {{DW{1'b0}}, c[i*DW +: DW]};
      p = p % {{DW{1'b0}}, q};
      r[i*DW +: DW] = p[DW-1:0];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle, queues the model sequence, then scrambles the
  // run inputs so any late sampling by the DUT would show up.
  task automatic launch(input logic m, input logic [STEPS_W-1:0] n, input logic [VW-1:0] b,
                        input logic [VW-1:0] cf, input logic [VW-1:0] ci,
                        input logic [DW-1:0] q, output int t_start);
    logic [VW-1:0] v;
    mode = m; num_steps = n; base_in = b; const_fwd_in = cf; const_inv_in = ci;
    modulus = q; start = 1'b1;
    t_start = cycle;
    v = b;
    for (int s = 0; s < int'(n); s++) begin
      exp_q.push_back(v);
      v = mulvec(v, m ? ci : cf, q);
    end
    tick();
    start = 1'b0;
    base_in = {LANES{$urandom()}};
    const_fwd_in = {LANES{$urandom()}};
    const_inv_in = {LANES{$urandom()}};
    modulus = $urandom();
    num_steps = STEPS_W'($urandom());
    mode = ~m;
  endtask

  // Consumes n vectors; optional 5-cycle stall on step stall_at; checks
  // first-vector latency when first_cycle >= 0 and the done pulse if asked.
  task automatic consume(input int n, input int stall_at, input int first_cycle,
                         input bit expect_done);
    int last_hs;
    int t0;
    logic [VW-1:0] e;
    out_ready = 1'b1;
    last_hs = 0;
    for (int s = 0; s < n; s++) begin
      if (s == stall_at) out_ready = 1'b0;
      t0 = cycle;
      while (!out_valid && (cycle - t0) < 40) tick();
      if (!out_valid) begin
        check("valid_timeout", VW'(0), VW'(1));
        out_ready = 1'b1;
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (s == 0 && first_cycle >= 0) check("first_latency", VW'(cycle), VW'(first_cycle));
      if (s > 0) check("vec_spacing", VW'(cycle - last_hs), VW'(MUL_LAT + 1));
      if (s == stall_at) begin
        repeat (5) begin
          check("stall_valid", VW'(out_valid), VW'(1));
          check("stall_idx", VW'(step_idx), VW'(s));
          check("stall_tf", tf_out, e);
          tick();
        end
        out_ready = 1'b1;
      end
      check("step_idx", VW'(step_idx), VW'(s));
      check("tf_vec", tf_out, e);
      if (lane0_q.size() > 0) check("lane0_hand", VW'(tf_out[DW-1:0]), VW'(lane0_q.pop_front()));
      last_hs = cycle;
      tick();
    end
    if (expect_done) begin
      check("done_pulse", VW'(done), VW'(1));
      check("done_valid_low", VW'(out_valid), VW'(0));
      check("done_busy", VW'(busy), VW'(1));
      tick();
      check("done_cleared", VW'(done), VW'(0));
      check("idle_busy", VW'(busy), VW'(0));
    end
  endtask

  function automatic logic [VW-1:0] fill_vec(input int mul, input int add, input int q);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'((i * mul + add) % q);
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec(input logic [DW-1:0] q);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = $urandom() % q;
    return r;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int t;
    logic [VW-1:0] b, cf, ci;
    logic [DW-1:0] q;

    rst = 1'b0; start = 1'b0; mode = 1'b0; num_steps = '0; base_in = '0;
    const_fwd_in = '0; const_inv_in = '0; modulus = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", VW'(out_valid), VW'(0));
    check("rst_tf", tf_out, '0);
    check("rst_idx", VW'(step_idx), VW'(0));
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    rst = 1'b1;
    tick();

    // Forward run, q=17, lane0 3*3^k -> 3, 9, 10, 13.
    b  = fill_vec(5, 1, 17);  b[DW-1:0]  = 32'd3;
    cf = fill_vec(3, 2, 17);  cf[DW-1:0] = 32'd3;
    ci = fill_vec(7, 4, 17);
    lane0_q.push_back(32'd3); lane0_q.push_back(32'd9);
    lane0_q.push_back(32'd10); lane0_q.push_back(32'd13);
    launch(1'b0, 4'd4, b, cf, ci, 32'd17, t);
    consume(4, -1, t + 1, 1'b1);

    // Inverse run, q=17, lane0 13*6^k -> 13, 10, 9; forward set differs.
    b  = fill_vec(4, 3, 17);  b[DW-1:0]  = 32'd13;
    cf = fill_vec(2, 1, 17);  cf[DW-1:0] = 32'd3;
    ci = fill_vec(6, 5, 17);  ci[DW-1:0] = 32'd6;
    lane0_q.push_back(32'd13); lane0_q.push_back(32'd10); lane0_q.push_back(32'd9);
    launch(1'b1, 4'd3, b, cf, ci, 32'd17, t);
    consume(3, -1, t + 1, 1'b1);

    // Back-pressure: 5-cycle stall on step 1.
    b  = fill_vec(11, 7, 97);
    cf = fill_vec(13, 5, 97);
    ci = fill_vec(3, 1, 97);
    launch(1'b0, 4'd4, b, cf, ci, 32'd97, t);
    consume(4, 1, t + 1, 1'b1);

    // Zero-length run: done at t+1, never valid.
    launch(1'b0, 4'd0, b, cf, ci, 32'd97, t);
    check("zero_done", VW'(done), VW'(1));
    check("zero_busy", VW'(busy), VW'(1));
    check("zero_valid", VW'(out_valid), VW'(0));
    tick();
    check("zero_done_clr", VW'(done), VW'(0));
    check("zero_busy_clr", VW'(busy), VW'(0));
    check("zero_valid_clr", VW'(out_valid), VW'(0));

    // Start while busy is ignored; current run completes unchanged.
    out_ready = 1'b0;
    b  = fill_vec(2, 9, 31);
    cf = fill_vec(5, 3, 31);
    ci = fill_vec(1, 1, 31);
    launch(1'b0, 4'd3, b, cf, ci, 32'd31, t);
    start = 1'b1; num_steps = 4'd7; base_in = fill_vec(1, 2, 31);
    repeat (2) tick();
    start = 1'b0;
    consume(3, -1, -1, 1'b1);
    tick();
    check("busy_start_ignored", VW'(busy), VW'(0));

    // Abort in WAIT after step 1.
    b  = fill_vec(3, 2, 17);
    cf = fill_vec(5, 4, 17);
    launch(1'b0, 4'd6, b, cf, ci, 32'd17, t);
    consume(2, -1, t + 1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", VW'(busy), VW'(0));
    check("abort_valid", VW'(out_valid), VW'(0));
    check("abort_done", VW'(done), VW'(0));
    exp_q.delete();
    repeat (3) begin
      tick();
      check("abort_stay_idle", VW'({busy, out_valid, done}), VW'(0));
    end
    b  = fill_vec(2, 1, 17);  b[DW-1:0]  = 32'd5;
    cf = fill_vec(4, 3, 17);  cf[DW-1:0] = 32'd3;
    lane0_q.push_back(32'd5); lane0_q.push_back(32'd15);
    launch(1'b0, 4'd2, b, cf, ci, 32'd17, t);
    consume(2, -1, t + 1, 1'b1);

    // Reset during EMIT at step 2, random modulus and operands.
    q  = $urandom_range(32'hFFFF_FFFF, 2);
    b  = rand_vec(q); cf = rand_vec(q); ci = rand_vec(q);
    launch(1'b0, 4'd15, b, cf, ci, q, t);
    consume(2, -1, t + 1, 1'b0);
    out_ready = 1'b0;
    t = cycle;
    while (!out_valid && (cycle - t) < 40) tick();
    check("pre_rst_idx", VW'(step_idx), VW'(2));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", VW'(out_valid), VW'(0));
    check("mid_rst_tf", tf_out, '0);
    check("mid_rst_idx", VW'(step_idx), VW'(0));
    check("mid_rst_busy", VW'(busy), VW'(0));
    check("mid_rst_done", VW'(done), VW'(0));
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) begin
      tick();
      check("post_rst_idle", VW'({busy, out_valid, done}), VW'(0));
    end
    q  = $urandom_range(32'hFFFF_FFFF, 2);
    b  = rand_vec(q); cf = rand_vec(q); ci = rand_vec(q);
    launch(1'b1, 4'd15, b, cf, ci, q, t);
    consume(15, -1, t + 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tf_gen_param.md
# tf_gen_param

Parametrised twiddle-factor generator for the NWC/NTT datapath. It emits a sequence of LANES-wide twiddle vectors, where each lane follows tf[k+1] = tf[k]·c mod q from a loaded base. The constant set is selectable per run: forward or inverse. Output uses a valid/ready handshake with full back-pressure. The block replaces fixed 15-lane TF generation: butterfly-array controllers start a run, then consume one vector per NTT stage step.

## Interface
Parameters:
- DW, 32, data and modulus width in bits
- LANES, 15, number of independent twiddle lanes
- STEPS_W, 4, width of step count/index (max run length 2^STEPS_W−1)
- MUL_LAT, 3, pipeline latency in cycles of the internal modular multiplier (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- start  in  1  request a run; accepted only in IDLE
- mode  in  1  0 = forward constants, 1 = inverse constants; sampled with start
- num_steps  in  STEPS_W  number of vectors to emit; sampled with start
- base_in  in  LANES*DW  lane i base at bits [i*DW +: DW]; sampled with start
- const_fwd_in  in  LANES*DW  forward per-lane multiplier
- const_inv_in  in  LANES*DW  inverse per-lane multiplier
- modulus  in  DW  q; sampled with start
- abort  in  1  synchronous run cancel
- out_valid  out  1  tf_out/step_idx valid
- out_ready  in  1  consumer accepts the vector
- tf_out  out  LANES*DW  current twiddle vector
- step_idx  out  STEPS_W  index k of tf_out, 0-based
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, EMIT, WAIT, DONE.
- IDLE:
  - start=1 and num_steps≠0: capture base_in into the lane registers, capture the constant set selected by mode, capture modulus and num_steps, clear k. Next state is EMIT.
  - start=1 and num_steps=0: next state is DONE. No vector is emitted.
- EMIT:
  - out_valid=1, tf_out = lane registers, step_idx = k.
  - On out_valid&out_ready with k = num_steps−1, next state is DONE.
  - On out_valid&out_ready otherwise, issue a multiply of every lane (lane × captured const, mod captured q) and go to WAIT with a countdown of MUL_LAT.
  - Without ready, stay in EMIT with all outputs held stable.
- WAIT: out_valid=0. When the countdown expires, write the multiplier results into the lane registers, increment k, and return to EMIT.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in any non-IDLE state: next state is IDLE. out_valid drops next cycle, no done pulse, and in-flight multiplier results are discarded. abort overrides a simultaneous handshake.
- start while busy is ignored. Changes to const/base/modulus inputs during a run have no effect.
- Arithmetic:
  - Each lane computes the full 2·DW product, reduced exactly: result = (a·b) mod q.
  - Any reduction method (e.g. Barrett) is acceptable if bit-exact for a, b < q and 2 ≤ q < 2^DW.
  - Inputs ≥ q are caller error; behaviour is then unspecified but must not hang the FSM.
- Lanes are independent. All lanes share the state machine, k and the handshake.

## Timing
- Reset (rst=0), asynchronous: state IDLE, lane regs/consts/modulus/k = 0, out_valid=0, tf_out=0, step_idx=0, busy=0, done=0.
- Start accepted in cycle t:
  - busy=1 and out_valid=1 from t+1, carrying the bases at step_idx 0.
  - With num_steps=0: done=1 at t+1, busy=1 at t+1 only.
- Handshake in cycle h with more steps remaining: WAIT covers h+1 … h+MUL_LAT, and the next vector is valid at h+MUL_LAT+1.
- Steady-state throughput with out_ready held high: one vector per MUL_LAT+1 cycles.
- Final handshake in cycle h: done=1 and out_valid=0 at h+1, busy=0 at h+2.
- A new start is accepted in the first IDLE cycle (h+2).
- Reset asserted mid-run: all outputs are at their reset values immediately. After release, the block stays in IDLE until a new start.

## Test plan
- Forward run: q=17, lane0 base 3 const_fwd 3, num_steps=4, out_ready=1 → tf_out lane0 = 3, 9, 10, 13 at step_idx 0–3; vectors spaced MUL_LAT+1 cycles apart; done pulse one cycle after the 4th handshake.
- Inverse run: q=17, lane0 base 13 const_inv 6, mode=1, num_steps=3 → 13, 10, 9; const_fwd values ignored.
- Back-pressure: drop out_ready for 5 cycles at step 1 → out_valid held, tf_out/step_idx stable; sequence resumes unchanged with no skipped or duplicated step.
- num_steps=0 → no out_valid; done=1 exactly at t+1. Also: start during busy is ignored, and the current run completes normally.
- Abort in WAIT after step 1 → IDLE next cycle, no done, busy=0. A new start with base 5 then emits 5 first, with no stale result.
- Reset pulse (rst=0) during EMIT at step 2 with LANES=15, random q < 2^32, random base/const < q → all outputs 0 immediately. A following full run matches a reference (a·b) mod q model on all 15 lanes across 15 steps.
